// File: rtl/fft_common_pkg.sv
// Types and constants shared by the FFT datapath control blocks.
package fft_common_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rate_mon_state_t;

    localparam int unsigned RATE_MON_SYNC_DEFAULT = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, plus rising-edge detection on the
// synchronised value.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History resets low, so a level already high at reset release reads as one edge.
    assign o_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clock_rate_monitor.sv
// Measures the period of a slow clock-like signal in i_clk cycles, strobes once per rising
// edge, and reports lock once LOCK_COUNT consecutive periods agree.
module clock_rate_monitor
    import fft_common_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned SYNC_STAGES = RATE_MON_SYNC_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    output logic             o_edge_stb,
    output logic [CNT_W-1:0] o_period,
    output logic             o_period_valid,
    output logic             o_locked,
    output logic             o_timeout
);

    localparam int unsigned        MATCH_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_1  = MATCH_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_CNT = MATCH_W'(LOCK_COUNT);

    logic rise;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_sig),
        .o_rise  (rise)
    );

    rate_mon_state_t    state_q, state_d;
    logic [CNT_W-1:0]   elapsed_q, elapsed_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               edge_stb_q, edge_stb_d;
    logic               period_valid_q, period_valid_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;
    logic               same_period;
    logic               timeout_cond;

    // elapsed_q reads 1 during the strobe cycle, so at the next edge it equals the period.
    assign same_period  = (elapsed_q == period_q);
    assign timeout_cond = (elapsed_q == CNT_MAX) && !rise;

    always_comb begin
        state_d        = state_q;
        match_d        = match_q;
        period_d       = period_q;
        locked_d       = locked_q;
        period_valid_d = 1'b0;
        timeout_d      = 1'b0;
        edge_stb_d     = rise;
        if (rise) begin
            elapsed_d = CNT_ONE;
        end else if (elapsed_q == CNT_MAX) begin
            elapsed_d = elapsed_q;
        end else begin
            elapsed_d = elapsed_q + CNT_ONE;
        end

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d       = elapsed_q;
                    period_valid_d = 1'b1;
                    match_d        = same_period ? match_q + MATCH_1 : MATCH_1;
                    if (match_d == LOCK_CNT) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end else if (timeout_cond) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    locked_d  = 1'b0;
                    match_d   = '0;
                    state_d   = IDLE;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_d       = elapsed_q;
                    period_valid_d = 1'b1;
                    if (!same_period) begin
                        match_d  = MATCH_1;
                        locked_d = 1'b0;
                        state_d  = MEASURE;
                    end
                end else if (timeout_cond) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    locked_d  = 1'b0;
                    match_d   = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= IDLE;
            elapsed_q      <= '0;
            match_q        <= '0;
            period_q       <= '0;
            edge_stb_q     <= 1'b0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            elapsed_q      <= elapsed_d;
            match_q        <= match_d;
            period_q       <= period_d;
            edge_stb_q     <= edge_stb_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign o_edge_stb     = edge_stb_q;
    assign o_period       = period_q;
    assign o_period_valid = period_valid_q;
    assign o_locked       = locked_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_clock_rate_monitor.sv
// Directed bench for clock_rate_monitor: period measurement, lock, relock, timeout and reset.
module tb_clock_rate_monitor;
    import fft_common_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig = 1'b0;
    logic       edge_stb;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       timeout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int per;
        bit val;
        bit lock;
    } stb_t;

    stb_t stbs[$];
    int   n_to;
    int   to_cyc;
    int   n_bad_valid;

    clock_rate_monitor #(
        .CNT_W       (8),
        .LOCK_COUNT  (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sig          (sig),
        .o_edge_stb     (edge_stb),
        .o_period       (period),
        .o_period_valid (period_valid),
        .o_locked       (locked),
        .o_timeout      (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe and pulse on the falling edge, clear of the active edge.
    always @(negedge clk) begin
        stb_t s;
        if (edge_stb) begin
            s.cyc  = cyc;
            s.per  = int'(period);
            s.val  = period_valid;
            s.lock = locked;
            stbs.push_back(s);
        end
        if (period_valid && !edge_stb) n_bad_valid++;
        if (timeout) begin
            n_to++;
            to_cyc = cyc;
        end
    end

    function automatic stb_t stb_at(input int k);
        stb_t s;
        s.cyc  = -1;
        s.per  = -1;
        s.val  = 1'b0;
        s.lock = 1'b0;
        if (k < stbs.size()) s = stbs[k];
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        stbs.delete();
        n_to        = 0;
        to_cyc      = -1;
        n_bad_valid = 0;
    endtask

    task automatic do_reset();
        sig = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic gen(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            sig = 1'b1;
            tick(hi);
            sig = 1'b0;
            tick(lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sig = 1'b0;
        tick(3);
        tests++;
        if ({edge_stb, period, period_valid, locked, timeout} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got stb=%b per=%0d val=%b lock=%b to=%b want all 0",
                     edge_stb, period, period_valid, locked, timeout);
        end
    endtask

    task automatic test_held_high();
        int r;
        rst = 1'b1;
        sig = 1'b1;
        tick(2);
        clear_log();
        r   = cyc;
        rst = 1'b0;
        tick(10);
        tests++;
        if (stbs.size() != 1) begin
            fails++;
            $display("FAIL held_high_count: got %0d strobes want 1", stbs.size());
        end
        tests++;
        if (stb_at(0).cyc - r != 3) begin
            fails++;
            $display("FAIL held_high_latency: got %0d cycles want 3", stb_at(0).cyc - r);
        end
        tests++;
        if (stb_at(0).val !== 1'b0 || n_bad_valid != 0) begin
            fails++;
            $display("FAIL held_high_valid: got val=%b stray=%0d want 0/0",
                     stb_at(0).val, n_bad_valid);
        end
        tests++;
        if (dut.state_q !== MEASURE) begin
            fails++;
            $display("FAIL held_high_state: got %0d want %0d", dut.state_q, MEASURE);
        end
        do_reset();
    endtask

    task automatic test_div4();
        do_reset();
        clear_log();
        gen(2, 2, 8);
        tick(4);
        tests++;
        if (stbs.size() != 8) begin
            fails++;
            $display("FAIL div4_count: got %0d want 8", stbs.size());
        end
        tests++;
        if (stb_at(0).val !== 1'b0 || stb_at(0).per != 0) begin
            fails++;
            $display("FAIL div4_first: got val=%b per=%0d want 0/0", stb_at(0).val, stb_at(0).per);
        end
        for (int k = 1; k < 8; k++) begin
            tests++;
            if (stb_at(k).per != 4 || stb_at(k).val !== 1'b1 ||
                stb_at(k).cyc - stb_at(k - 1).cyc != 4) begin
                fails++;
                $display("FAIL div4_strobe%0d: got per=%0d val=%b gap=%0d want 4/1/4", k,
                         stb_at(k).per, stb_at(k).val, stb_at(k).cyc - stb_at(k - 1).cyc);
            end
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (stb_at(k).lock !== (k >= 4)) begin
                fails++;
                $display("FAIL div4_lock%0d: got %b want %b", k, stb_at(k).lock, k >= 4);
            end
        end
        tests++;
        if (n_bad_valid != 0) begin
            fails++;
            $display("FAIL div4_stray_valid: got %0d want 0", n_bad_valid);
        end
    endtask

    task automatic test_relock();
        do_reset();
        clear_log();
        gen(4, 4, 6);
        gen(6, 6, 5);
        tick(4);
        tests++;
        if (stbs.size() != 11) begin
            fails++;
            $display("FAIL relock_count: got %0d want 11", stbs.size());
        end
        tests++;
        if (stb_at(6).per != 8 || stb_at(6).lock !== 1'b1) begin
            fails++;
            $display("FAIL relock_pre: got per=%0d lock=%b want 8/1", stb_at(6).per, stb_at(6).lock);
        end
        tests++;
        if (stb_at(7).per != 12 || stb_at(7).lock !== 1'b0) begin
            fails++;
            $display("FAIL relock_drop: got per=%0d lock=%b want 12/0", stb_at(7).per, stb_at(7).lock);
        end
        tests++;
        if (stb_at(8).lock !== 1'b0 || stb_at(9).lock !== 1'b0) begin
            fails++;
            $display("FAIL relock_early: got %b%b want 00", stb_at(8).lock, stb_at(9).lock);
        end
        tests++;
        if (stb_at(10).per != 12 || stb_at(10).lock !== 1'b1) begin
            fails++;
            $display("FAIL relock_regain: got per=%0d lock=%b want 12/1",
                     stb_at(10).per, stb_at(10).lock);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        clear_log();
        gen(8, 8, 6);
        tick(300);
        tests++;
        if (stbs.size() != 6 || stb_at(5).lock !== 1'b1 || stb_at(5).per != 16) begin
            fails++;
            $display("FAIL timeout_pre: got n=%0d lock=%b per=%0d want 6/1/16",
                     stbs.size(), stb_at(5).lock, stb_at(5).per);
        end
        tests++;
        if (n_to != 1 || to_cyc - stb_at(5).cyc != 255) begin
            fails++;
            $display("FAIL timeout_pulse: got n=%0d delay=%0d want 1/255",
                     n_to, to_cyc - stb_at(5).cyc);
        end
        tests++;
        if (period !== 8'd0 || locked !== 1'b0) begin
            fails++;
            $display("FAIL timeout_state: got per=%0d lock=%b want 0/0", period, locked);
        end
        tick(300);
        tests++;
        if (n_to != 1) begin
            fails++;
            $display("FAIL timeout_once: got %0d pulses want 1", n_to);
        end
    endtask

    task automatic test_max_period();
        do_reset();
        clear_log();
        gen(127, 128, 6);
        tests++;
        if (n_to != 0) begin
            fails++;
            $display("FAIL maxper_timeout: got %0d pulses want 0", n_to);
        end
        for (int k = 1; k < 6; k++) begin
            tests++;
            if (stb_at(k).per != 255) begin
                fails++;
                $display("FAIL maxper_period%0d: got %0d want 255", k, stb_at(k).per);
            end
        end
        tests++;
        if (stb_at(3).lock !== 1'b0 || stb_at(4).lock !== 1'b1 || period !== 8'd255) begin
            fails++;
            $display("FAIL maxper_lock: got %b%b per=%0d want 01/255",
                     stb_at(3).lock, stb_at(4).lock, period);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        clear_log();
        gen(2, 2, 6);
        tests++;
        if (locked !== 1'b1 || period !== 8'd4) begin
            fails++;
            $display("FAIL midrst_pre: got lock=%b per=%0d want 1/4", locked, period);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({edge_stb, period, period_valid, locked, timeout} !== 12'h000) begin
            fails++;
            $display("FAIL midrst_clear: got stb=%b per=%0d val=%b lock=%b to=%b want all 0",
                     edge_stb, period, period_valid, locked, timeout);
        end
        tick(1);
        rst = 1'b0;
        clear_log();
        gen(2, 2, 6);
        tests++;
        if (stbs.size() != 6 || stb_at(3).lock !== 1'b0 || stb_at(4).lock !== 1'b1) begin
            fails++;
            $display("FAIL midrst_relock: got n=%0d lock3=%b lock4=%b want 6/0/1",
                     stbs.size(), stb_at(3).lock, stb_at(4).lock);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_held_high();
        test_div4();
        test_relock();
        test_timeout();
        test_max_period();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
